uart_rx_deser_fifo: RTL and testbench
=====================================

# uart_rx_deser_fifo

Parametrised UART receive deserializer with a word output FIFO. It sits between the Rx bit sampler/FSM and the bus-facing UART register block. It assembles a runtime-configurable 5..MAX_WIDTH-bit data word in LSB-first or MSB-first order and buffers completed words in a FIFO. Overrun is reported when the FIFO cannot accept a completed word.

## Interface
- MAX_WIDTH, default 9: maximum data bits per word; legal range 8..9.
- FIFO_DEPTH, default 4: FIFO entries; power of two, at least 2.
- CLK  in  1  clock; all state is updated on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- Frame_Start  in  1  one-cycle pulse at start-bit acceptance; begins a new word.
- Deser_En  in  1  one-cycle pulse per data bit; Sampled_Bit is valid in that cycle.
- Sampled_Bit  in  1  received data bit.
- Data_Len  in  4  data bits per word; latched on Frame_Start.
- Msb_First  in  1  0 = LSB first, 1 = MSB first; latched on Frame_Start.
- Rd_En  in  1  pop the FIFO head.
- Clr_Overrun  in  1  clears Overrun.
- P_DATA  out  MAX_WIDTH  FIFO head word, right-aligned; bits at and above the latched length are 0.
- Data_Valid  out  1  FIFO not empty.
- Word_Done  out  1  one-cycle pulse per word pushed into the FIFO.
- Overrun  out  1  sticky flag: a word was dropped because the FIFO was full.
- Fifo_Count  out  clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

## Operation
- **Config latch:** on Frame_Start, the block latches Data_Len and Msb_First.
  - Data_Len < 5 is clamped to 5.
  - Data_Len > MAX_WIDTH is clamped to MAX_WIDTH.
  - Reset value of the latched config: length 8, LSB first.
- **Frame_Start:** clears the shift register SR and the bit counter cnt to 0, and arms assembly.
  - Frame_Start mid-word abandons the partial word: no push, no Word_Done.
- **Bit write:** each armed Deser_En writes Sampled_Bit into SR.
  - LSB first: SR[cnt].
  - MSB first: SR[len-1-cnt].
  - cnt then increments.
- **Word completion:** the Deser_En with cnt == len-1 completes the word.
  - The assembled SR, including the current bit, is pushed into the FIFO at that same edge.
  - Assembly then disarms.
- **Disarmed:** Deser_En is ignored until the next Frame_Start.
- **Frame_Start and Deser_En in the same cycle:** Frame_Start wins; the bit is discarded.
- **FIFO:** circular buffer with read/write pointers and an occupancy counter.
  - P_DATA is driven from the head entry. When empty, P_DATA holds 0.
  - Pop on Rd_En && Data_Valid. Rd_En while empty is ignored.
- **Push while full:**
  - With a simultaneous pop: both occur, Fifo_Count is unchanged, no overrun.
  - Without a pop: the word is dropped, Overrun is set, Word_Done still pulses, and FIFO contents are unchanged.
- **Push while empty, same cycle as Rd_En:** Rd_En is ignored (empty); the push proceeds.
- **Overrun:** cleared by Clr_Overrun. If a set condition and Clr_Overrun occur in the same cycle, set wins.

## Timing
- **Reset values:** P_DATA 0, Data_Valid 0, Word_Done 0, Overrun 0, Fifo_Count 0; SR, cnt, pointers 0; disarmed.
- **Latency:** final Deser_En in cycle N gives Word_Done, Data_Valid and the updated Fifo_Count in cycle N+1. P_DATA shows the word in cycle N+1 if the FIFO was empty.
- **Pop:** Rd_En in cycle N; the next head (or 0) appears on P_DATA, with Fifo_Count decremented, in cycle N+1.
- **Outputs:** all outputs are registered or driven directly from registers; there are no combinational paths from inputs to outputs.
- **Minimum spacing:** Deser_En pulses may arrive in back-to-back cycles and Frame_Start may follow a completed word immediately. Full throughput is one bit per cycle.
- **Reset mid-operation:** reset asynchronously clears everything. The FIFO contents are lost and Data_Valid drops immediately.

## Test plan
- Data_Len=8, LSB first, bits 1,0,1,0,0,1,0,1 → one cycle after the 8th Deser_En: P_DATA=0x0A5, Word_Done pulses once, Fifo_Count=1.
- Data_Len=8, MSB first, bits 1,0,1,0,0,1,0,1 → P_DATA=0x0A5; then Data_Len=5, MSB first, bits 1,1,0,0,1 → second entry 0x019 with bits 8:5 = 0.
- Data_Len=3, then Data_Len=15 → clamped to 5 and 9 respectively. A 9-bit LSB-first all-ones word gives P_DATA=0x1FF; a 10th Deser_En is ignored.
- Push 4 words (0x11..0x14) without reading, then a 5th (0x15) → Overrun=1, Fifo_Count=4, Word_Done pulses. Reads return 0x11..0x14 in order, then Data_Valid=0. Repeat with Rd_En coincident with the 5th push → no overrun, last read returns 0x15.
- Frame_Start after 3 bits, then a full 8-bit word 0x3C → only 0x3C is in the FIFO. Frame_Start and Deser_En in the same cycle → the bit is dropped and cnt=0.
- Assert RST with 2 words queued and a partial frame in progress → all outputs 0 immediately. Clr_Overrun in the same cycle as an overrun set → Overrun stays 1.

Source files
------------

// File: rtl/uart_rx_deser_fifo.sv
// UART receive deserializer: assembles 5..MAX_WIDTH-bit words LSB/MSB first
// and queues completed words in a small FIFO with a sticky overrun flag.
module uart_rx_deser_fifo #(
  parameter int MAX_WIDTH  = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Frame_Start,
  input  logic                          Deser_En,
  input  logic                          Sampled_Bit,
  input  logic [3:0]                    Data_Len,
  input  logic                          Msb_First,
  input  logic                          Rd_En,
  input  logic                          Clr_Overrun,
  output logic [MAX_WIDTH-1:0]          P_DATA,
  output logic                          Data_Valid,
  output logic                          Word_Done,
  output logic                          Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_WIDTH);

  logic [3:0]           len;
  logic [3:0]           len_in;
  logic [3:0]           cnt;
  logic                 msb;
  logic                 armed;
  logic [MAX_WIDTH-1:0] sr;
  logic [MAX_WIDTH-1:0] sr_next;
  logic [IW-1:0]        idx;
  logic                 done;

  logic [MAX_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 pop;
  logic                 wr;
  logic                 ovr_set;

  always_comb begin
    len_in = Data_Len;
    if (Data_Len < 4'd5)
      len_in = 4'd5;
    else if (Data_Len > 4'(MAX_WIDTH))
      len_in = 4'(MAX_WIDTH);
  end

  always_comb begin
    idx = msb ? IW'(len - 4'd1 - cnt) : IW'(cnt);
    sr_next = sr;
    sr_next[idx] = Sampled_Bit;
  end

  // Frame_Start has priority: a coincident bit is discarded.
  assign done = armed && Deser_En && !Frame_Start
             && (cnt == len - 4'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len   <= 4'd8;
      msb   <= 1'b0;
      sr    <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else if (Frame_Start) begin
      len   <= len_in;
      msb   <= Msb_First;
      sr    <= '0;
      cnt   <= '0;
      armed <= 1'b1;
    end else if (armed && Deser_En) begin
      sr  <= sr_next;
      cnt <= cnt + 4'd1;
      if (done)
        armed <= 1'b0;
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = Rd_En && (count != '0);
  assign wr      = done && (!full || pop);
  assign ovr_set = done && full && !pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= sr_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      Word_Done <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count + CW'(wr) - CW'(pop);
      Word_Done <= done;
      if (ovr_set)
        Overrun <= 1'b1;
      else if (Clr_Overrun)
        Overrun <= 1'b0;
    end
  end

  assign Data_Valid = (count != '0);
  assign P_DATA     = Data_Valid ? mem[rd_ptr] : '0;
  assign Fifo_Count = count;

endmodule

// File: tb/tb_uart_rx_deser_fifo.sv
// Self-checking bench for uart_rx_deser_fifo against a queue-based
// word-level reference model.
module tb_uart_rx_deser_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Frame_Start = 1'b0;
  logic       Deser_En = 1'b0;
  logic       Sampled_Bit = 1'b0;
  logic [3:0] Data_Len = 4'd8;
  logic       Msb_First = 1'b0;
  logic       Rd_En = 1'b0;
  logic       Clr_Overrun = 1'b0;
  logic [8:0] P_DATA;
  logic       Data_Valid;
  logic       Word_Done;
  logic       Overrun;
  logic [2:0] Fifo_Count;

  int pass_cnt = 0;
  int total = 0;

  int q[$];
  bit m_ovr = 0;

  uart_rx_deser_fifo #(.MAX_WIDTH(9), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .Frame_Start(Frame_Start), .Deser_En(Deser_En),
    .Sampled_Bit(Sampled_Bit), .Data_Len(Data_Len),
    .Msb_First(Msb_First), .Rd_En(Rd_En),
    .Clr_Overrun(Clr_Overrun), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Word_Done(Word_Done),
    .Overrun(Overrun), .Fifo_Count(Fifo_Count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int head();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  // Sends one frame; the model decides the outcome from word-level rules.
  task automatic send(input int dl, input bit msb, input int w,
                      input bit rd_last, input bit clr_last);
    int len;
    int word;
    bit full;
    bit pop;
    len = (dl < 5) ? 5 : ((dl > 9) ? 9 : dl);
    word = w & ((1 << len) - 1);
    Frame_Start = 1; Data_Len = dl[3:0]; Msb_First = msb;
    step();
    Frame_Start = 0;
    for (int k = 0; k < len; k++) begin
      Sampled_Bit = msb ? ((word >> (len - 1 - k)) & 1)
                        : ((word >> k) & 1);
      Deser_En = 1;
      if (k == len - 1) begin
        Rd_En = rd_last;
        Clr_Overrun = clr_last;
      end
      step();
      Deser_En = 0; Rd_En = 0; Clr_Overrun = 0;
    end
    full = (q.size() == 4);
    pop = rd_last && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (full && !pop) m_ovr = 1;
    else begin
      q.push_back(word);
      if (clr_last) m_ovr = 0;
    end
  endtask

  task automatic pop_one();
    Rd_En = 1;
    step();
    Rd_En = 0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic drain();
    while (q.size() > 0) pop_one();
    Clr_Overrun = 1; step(); Clr_Overrun = 0;
    m_ovr = 0;
  endtask

  task automatic test_reset();
    RST = 0;
    #1;
    total++;
    if ({P_DATA, Data_Valid, Word_Done, Overrun, Fifo_Count} !== '0)
      $display("FAIL reset: outputs=%h required 0",
               {P_DATA, Data_Valid, Word_Done, Overrun, Fifo_Count});
    else pass_cnt++;
    step();
    RST = 1;
    step();
  endtask

  task automatic test_lsb_msb();
    send(8, 0, 'hA5, 0, 0);
    total++;
    if (P_DATA !== 9'h0A5 || Word_Done !== 1 || Fifo_Count !== 1)
      $display("FAIL lsb8: data=%h done=%b cnt=%0d required a5/1/1",
               P_DATA, Word_Done, Fifo_Count);
    else pass_cnt++;
    step();
    total++;
    if (Word_Done !== 0)
      $display("FAIL done_pulse: done=%b required 0", Word_Done);
    else pass_cnt++;
    pop_one();
    send(8, 1, 'hA5, 0, 0);
    send(5, 1, 'h19, 0, 0);
    total++;
    if (P_DATA !== 9'h0A5 || Fifo_Count !== 2)
      $display("FAIL msb8: data=%h cnt=%0d required a5/2",
               P_DATA, Fifo_Count);
    else pass_cnt++;
    pop_one();
    total++;
    if (P_DATA !== 9'h019 || Fifo_Count !== 1)
      $display("FAIL msb5: data=%h cnt=%0d required 019/1",
               P_DATA, Fifo_Count);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_clamp();
    send(3, 0, 'h1F, 0, 0);
    total++;
    if (Word_Done !== 1 || P_DATA !== 9'h01F)
      $display("FAIL clamp5: done=%b data=%h required 1/01f",
               Word_Done, P_DATA);
    else pass_cnt++;
    pop_one();
    send(15, 0, 'h1FF, 0, 0);
    total++;
    if (Word_Done !== 1 || P_DATA !== 9'h1FF)
      $display("FAIL clamp9: done=%b data=%h required 1/1ff",
               Word_Done, P_DATA);
    else pass_cnt++;
    Sampled_Bit = 1; Deser_En = 1;
    step();
    Deser_En = 0;
    step();
    total++;
    if (Fifo_Count !== 1 || Word_Done !== 0)
      $display("FAIL extra_bit: cnt=%0d done=%b required 1/0",
               Fifo_Count, Word_Done);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 4; i++) send(8, 0, 'h11 + i, 0, 0);
    send(8, 0, 'h15, 0, 0);
    total++;
    if (Overrun !== 1 || Fifo_Count !== 4 || Word_Done !== 1)
      $display("FAIL ovr_set: ovr=%b cnt=%0d done=%b required 1/4/1",
               Overrun, Fifo_Count, Word_Done);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (P_DATA !== 9'(head()))
        $display("FAIL ovr_read%0d: data=%h required %h",
                 i, P_DATA, head());
      else pass_cnt++;
      pop_one();
    end
    total++;
    if (Data_Valid !== 0 || P_DATA !== 0)
      $display("FAIL empty: valid=%b data=%h required 0/0",
               Data_Valid, P_DATA);
    else pass_cnt++;
    Rd_En = 1; step(); Rd_En = 0;
    total++;
    if (Fifo_Count !== 0)
      $display("FAIL rd_empty: cnt=%0d required 0", Fifo_Count);
    else pass_cnt++;
    Clr_Overrun = 1; step(); Clr_Overrun = 0; m_ovr = 0;
    total++;
    if (Overrun !== 0)
      $display("FAIL ovr_clr: ovr=%b required 0", Overrun);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) send(8, 0, 'h11 + i, 0, 0);
    send(8, 0, 'h15, 1, 0);
    total++;
    if (Overrun !== 0 || Fifo_Count !== 4)
      $display("FAIL full_pop: ovr=%b cnt=%0d required 0/4",
               Overrun, Fifo_Count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) pop_one();
    total++;
    if (P_DATA !== 9'h015)
      $display("FAIL last_read: data=%h required 015", P_DATA);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_abandon();
    Frame_Start = 1; Data_Len = 8; Msb_First = 0;
    step();
    Frame_Start = 0;
    for (int k = 0; k < 3; k++) begin
      Sampled_Bit = 1; Deser_En = 1; step(); Deser_En = 0;
    end
    send(8, 0, 'h3C, 0, 0);
    total++;
    if (Fifo_Count !== 1 || P_DATA !== 9'h03C)
      $display("FAIL abandon: cnt=%0d data=%h required 1/03c",
               Fifo_Count, P_DATA);
    else pass_cnt++;
    pop_one();
    Frame_Start = 1; Deser_En = 1; Sampled_Bit = 1;
    Data_Len = 8; Msb_First = 0;
    step();
    Frame_Start = 0; Deser_En = 0;
    for (int k = 0; k < 8; k++) begin
      Sampled_Bit = ('h5A >> k) & 1; Deser_En = 1;
      step();
      Deser_En = 0;
      if (k == 6) begin
        total++;
        if (Word_Done !== 0)
          $display("FAIL fs_de_early: done=%b required 0", Word_Done);
        else pass_cnt++;
      end
    end
    q.push_back('h5A);
    total++;
    if (Word_Done !== 1 || P_DATA !== 9'h05A)
      $display("FAIL fs_de: done=%b data=%h required 1/05a",
               Word_Done, P_DATA);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      send($urandom_range(15), 1'($urandom), $urandom_range(511),
           1'($urandom_range(3) == 0), 1'($urandom_range(7) == 0));
      total++;
      if (P_DATA !== 9'(head()) || Fifo_Count !== 3'(q.size())
          || Overrun !== m_ovr || Word_Done !== 1)
        $display("FAIL rand%0d: data=%h cnt=%0d ovr=%b required %h/%0d/%b",
                 n, P_DATA, Fifo_Count, Overrun, head(), q.size(), m_ovr);
      else pass_cnt++;
      if ($urandom_range(2) == 0) pop_one();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send(8, 0, 'h21, 0, 0);
    send(8, 0, 'h22, 0, 0);
    Frame_Start = 1; Data_Len = 8; step(); Frame_Start = 0;
    for (int k = 0; k < 3; k++) begin
      Sampled_Bit = 1; Deser_En = 1; step(); Deser_En = 0;
    end
    #2;
    RST = 0;
    #1;
    total++;
    if ({P_DATA, Data_Valid, Word_Done, Overrun, Fifo_Count} !== '0)
      $display("FAIL reset_mid: outputs=%h required 0",
               {P_DATA, Data_Valid, Word_Done, Overrun, Fifo_Count});
    else pass_cnt++;
    q.delete(); m_ovr = 0;
    step();
    RST = 1;
    Sampled_Bit = 1; Deser_En = 1;
    for (int k = 0; k < 6; k++) step();
    Deser_En = 0;
    step();
    total++;
    if (Fifo_Count !== 0)
      $display("FAIL disarmed: cnt=%0d required 0", Fifo_Count);
    else pass_cnt++;
  endtask

  task automatic test_clr_and_set();
    for (int i = 0; i < 4; i++) send(6, 1, 'h30 + i, 0, 0);
    send(6, 1, 'h3F, 0, 1);
    total++;
    if (Overrun !== 1 || Fifo_Count !== 4)
      $display("FAIL set_wins: ovr=%b cnt=%0d required 1/4",
               Overrun, Fifo_Count);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_lsb_msb();
    test_clamp();
    test_overrun();
    test_abandon();
    test_random();
    test_reset_mid();
    test_clr_and_set();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
